myproject_div_seq_23s_7ns_16s: RTL and testbench

//  Sequential signed/unsigned divider; inverse of the 7ns x 16s -> 23s product multiplier.

---
 rtl/myproject_div_seq_23s_7ns_16s_if.sv | 28 ++
 rtl/myproject_div_seq_23s_7ns_16s.sv | 144 ++++++++++++++
 tb/tb_myproject_div_seq_23s_7ns_16s.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/myproject_div_seq_23s_7ns_16s_if.sv
// Valid/ready operand and result bundle for the sequential 23s / 7ns -> 16s divider.
// master = upstream/downstream side, slave = the divider.
interface myproject_div_seq_23s_7ns_16s_if #(
  parameter int DIVIDEND_W = 23,
  parameter int DIVISOR_W  = 7,
  parameter int QUOT_W     = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [QUOT_W-1:0]     quotient;
  logic [DIVISOR_W:0]    remainder;
  logic                  ovf;
  logic                  dbz;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, ovf, dbz
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, ovf, dbz
  );
endinterface

// File: rtl/myproject_div_seq_23s_7ns_16s.sv
// Radix-2 restoring divider: signed 23-bit dividend / unsigned 7-bit divisor,
// saturating signed 16-bit quotient, one division in flight, 1 quotient bit per cycle.
module myproject_div_seq_23s_7ns_16s #(
  parameter int DIVIDEND_W = 23,
  parameter int DIVISOR_W  = 7,
  parameter int QUOT_W     = 16
) (
  input  logic ap_clk,
  input  logic ap_rst,
  myproject_div_seq_23s_7ns_16s_if.slave bus
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam int REM_W = DIVISOR_W + 1;
  localparam logic [DIVIDEND_W-1:0] POS_LIM = DIVIDEND_W'((1 << (QUOT_W - 1)) - 1);
  localparam logic [DIVIDEND_W-1:0] NEG_LIM = DIVIDEND_W'(1 << (QUOT_W - 1));
  localparam logic [QUOT_W-1:0]     Q_MAX   = {1'b0, {(QUOT_W - 1){1'b1}}};
  localparam logic [QUOT_W-1:0]     Q_MIN   = {1'b1, {(QUOT_W - 1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DIVIDEND_W-1:0] mag_q;
  logic [DIVISOR_W-1:0]  divisor_q;
  logic [DIVISOR_W-1:0]  rem_q;
  logic                  sign_q;
  logic                  dbz_op_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic [QUOT_W-1:0]     quotient_q;
  logic [REM_W-1:0]      remainder_q;
  logic                  ovf_q;
  logic                  dbz_q;

  // mag_q shifts dividend bits out at the top and quotient bits in at the bottom,
  // so after the last step it holds the magnitude quotient.
  logic [REM_W-1:0]      partial;
  logic                  qbit;
  logic [DIVISOR_W-1:0]  rem_d;
  logic [DIVIDEND_W-1:0] mag_d;

  always_comb begin
    partial = {rem_q, mag_q[DIVIDEND_W-1]};
    qbit    = (partial >= {1'b0, divisor_q});
    rem_d   = qbit ? DIVISOR_W'(partial - {1'b0, divisor_q}) : partial[DIVISOR_W-1:0];
    mag_d   = {mag_q[DIVIDEND_W-2:0], qbit};
  end

  logic [QUOT_W-1:0] quot_d;
  logic [REM_W-1:0]  remo_d;
  logic              ovf_d;

  always_comb begin
    quot_d = '0;
    remo_d = '0;
    ovf_d  = 1'b0;
    if (dbz_op_q) begin
      quot_d = sign_q ? Q_MIN : Q_MAX;
      ovf_d  = 1'b1;
    end else begin
      remo_d = sign_q ? (REM_W'(0) - {1'b0, rem_d}) : {1'b0, rem_d};
      if (!sign_q) begin
        if (mag_d > POS_LIM) begin
          quot_d = Q_MAX;
          ovf_d  = 1'b1;
        end else begin
          quot_d = mag_d[QUOT_W-1:0];
        end
      end else begin
        if (mag_d > NEG_LIM) begin
          quot_d = Q_MIN;
          ovf_d  = 1'b1;
        end else begin
          quot_d = QUOT_W'(0) - mag_d[QUOT_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mag_q       <= '0;
      divisor_q   <= '0;
      rem_q       <= '0;
      sign_q      <= 1'b0;
      dbz_op_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            mag_q      <= bus.dividend[DIVIDEND_W-1] ? (DIVIDEND_W'(0) - bus.dividend)
                                                     : bus.dividend;
            divisor_q  <= bus.divisor;
            sign_q     <= bus.dividend[DIVIDEND_W-1];
            dbz_op_q   <= (bus.divisor == '0);
            rem_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_CALC;
          end
        end
        S_CALC: begin
          mag_q <= mag_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DIVIDEND_W - 1)) begin
            quotient_q  <= quot_d;
            remainder_q <= remo_d;
            ovf_q       <= ovf_d;
            dbz_q       <= dbz_op_q;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.ovf       = ovf_q;
  assign bus.dbz       = dbz_q;

endmodule

// File: tb/tb_myproject_div_seq_23s_7ns_16s.sv
// Scoreboard bench for the sequential divider: directed cases, async abort, random pairs.
module tb_myproject_div_seq_23s_7ns_16s;

  logic ap_clk = 1'b0;
  logic ap_rst;
  always #5 ap_clk = ~ap_clk;

  myproject_div_seq_23s_7ns_16s_if bus ();

  myproject_div_seq_23s_7ns_16s dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  typedef struct {
    int q;
    int r;
    int ovf;
    int dbz;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Integer reference: truncating divide, remainder takes the dividend's sign.
  function automatic exp_t model(input int dvd, input int dvs);
    exp_t e;
    int   q;
    e.dbz = (dvs == 0) ? 1 : 0;
    if (dvs == 0) begin
      e.q   = (dvd >= 0) ? 32767 : -32768;
      e.r   = 0;
      e.ovf = 1;
    end else begin
      q     = dvd / dvs;
      e.r   = dvd % dvs;
      e.ovf = 0;
      if (q > 32767) begin
        q     = 32767;
        e.ovf = 1;
      end else if (q < -32768) begin
        q     = -32768;
        e.ovf = 1;
      end
      e.q = q;
    end
    return e;
  endfunction

  // Returns at the falling edge after the accepting rising edge.
  task automatic accept_op(input int dvd, input int dvs, output bit ok);
    int guard;
    guard = 0;
    @(negedge ap_clk);
    bus.in_valid = 1'b1;
    bus.dividend = dvd[22:0];
    bus.divisor  = dvs[6:0];
    while (!bus.in_ready && guard < 100) begin
      @(negedge ap_clk);
      guard++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    @(posedge ap_clk);
    ok = 1'b1;
    @(negedge ap_clk);
    bus.in_valid = 1'b0;
    check("busy_in_ready", int'(bus.in_ready), 0);
  endtask

  task automatic do_txn(input int dvd, input int dvs, input int hold);
    bit   ok;
    int   lat;
    int   q;
    int   r;
    exp_t e;
    accept_op(dvd, dvs, ok);
    if (!ok) return;
    sb.push_back(model(dvd, dvs));
    // the accepting edge counts as edge 1
    lat = 1;
    while (!bus.out_valid && lat < 60) begin
      @(posedge ap_clk);
      lat++;
      @(negedge ap_clk);
    end
    check("latency", lat, 24);
    e = sb.pop_front();
    if (!bus.out_valid) return;
    for (int i = 0; i < hold; i++) begin
      @(negedge ap_clk);
      check("hold_valid", int'(bus.out_valid), 1);
      check("hold_in_ready", int'(bus.in_ready), 0);
      check("hold_quot", int'($signed(bus.quotient)), e.q);
    end
    q = int'($signed(bus.quotient));
    r = int'($signed(bus.remainder));
    check("quotient", q, e.q);
    check("remainder", r, e.r);
    check("ovf", int'(bus.ovf), e.ovf);
    check("dbz", int'(bus.dbz), e.dbz);
    if (e.ovf == 0 && e.dbz == 0) check("invariant", q * dvs + r, dvd);
    $display("txn dvd=%0d dvs=%0d q=%0d r=%0d ovf=%0b dbz=%0b lat=%0d hold=%0d",
             dvd, dvs, q, r, bus.ovf, bus.dbz, lat, hold);
    bus.out_ready = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    bus.out_ready = 1'b0;
    check("drain_valid", int'(bus.out_valid), 0);
    check("idle_in_ready", int'(bus.in_ready), 1);
  endtask

  initial begin
    bit           ok;
    int           dvs;
    int           dvd;
    int           lim;
    logic [22:0]  r23;

    ap_rst        = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(negedge ap_clk);
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_quotient", int'(bus.quotient), 0);
    check("rst_remainder", int'(bus.remainder), 0);
    check("rst_ovf", int'(bus.ovf), 0);
    check("rst_dbz", int'(bus.dbz), 0);
    ap_rst = 1'b0;
    repeat (2) @(negedge ap_clk);

    do_txn(4191, 127, 0);
    do_txn(-100, 7, 0);
    do_txn(4194303, 1, 0);
    do_txn(-32768, 1, 0);
    do_txn(-5, 0, 0);
    do_txn(5, 0, 0);
    do_txn(0, 9, 0);
    do_txn(-4194304, 127, 0);
    do_txn(-4161536, 127, 0);
    do_txn(32767 * 127 + 126, 127, 0);
    do_txn(-5, 7, 0);
    // back-to-back with a stalled consumer on the first result
    do_txn(-30000, 3, 10);
    do_txn(12345, 11, 0);

    // async abort mid-calculation; outputs from the previous result must clear at once
    accept_op(77777, 13, ok);
    if (ok) begin
      repeat (10) @(posedge ap_clk);
      #2 ap_rst = 1'b1;
      #1;
      check("abort_out_valid", int'(bus.out_valid), 0);
      check("abort_in_ready", int'(bus.in_ready), 0);
      check("abort_quotient", int'(bus.quotient), 0);
      check("abort_remainder", int'(bus.remainder), 0);
      @(negedge ap_clk);
      ap_rst = 1'b0;
      repeat (2) @(negedge ap_clk);
    end
    do_txn(1000, 9, 0);

    for (int i = 0; i < 300; i++) begin
      dvs = (i % 17 == 0) ? 0 : int'($urandom_range(1, 127));
      if (i % 3 == 0) begin
        r23 = 23'($urandom);
        dvd = int'($signed(r23));
      end else begin
        lim = 32768 * ((dvs == 0) ? 1 : dvs);
        if (lim > 4194303) lim = 4194303;
        dvd = int'($urandom_range(0, 2 * lim)) - lim;
      end
      do_txn(dvd, dvs, (i % 5 == 0) ? int'($urandom_range(0, 3)) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
